dmi_arbiter: RTL and testbench

Two-to-one round-robin arbiter sharing the single Debug Module Interface (DMI) port of the debug module between two DMI requesters, e.g. the JTAG TAP / simulation socket link and an on-chip host agent. The block allows exactly one transaction in flight at a time: it latches the granted request, issues it downstream, captures the response, and returns it only to the owning requester. It sits between the requester-side DMI ports and the debug module's DMI port in the SoC debug subsystem.

---
 rtl/dmi_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_dmi_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: two-requester round-robin arbiter in front of a single DMI port.
// One transaction is in flight at a time; the response goes back only to the requester
// that issued it. Fairness: after each completed transaction the other requester is favoured.
// Optional feature macro DMI_ARB_TIMEOUT_EN: abandon a request that gets no downstream
// handshake/response within TIMEOUT_CYCLES and return a failed (2) response instead.
module dmi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RST_N,
  // requester 0
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [6:0]  m0_req_addr,
  input  logic [31:0] m0_req_data,
  input  logic [1:0]  m0_req_op,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_data,
  output logic [1:0]  m0_rsp_response,
  // requester 1
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [6:0]  m1_req_addr,
  input  logic [31:0] m1_req_data,
  input  logic [1:0]  m1_req_op,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_data,
  output logic [1:0]  m1_rsp_response,
  // downstream debug module
  output logic        dmi_req_valid,
  input  logic        dmi_req_ready,
  output logic [6:0]  dmi_req_addr,
  output logic [31:0] dmi_req_data,
  output logic [1:0]  dmi_req_op,
  output logic        dmi_rsp_ready,
  input  logic        dmi_rsp_valid,
  input  logic [31:0] dmi_rsp_data,
  input  logic [1:0]  dmi_rsp_response,
  // status
  output logic        busy,
  output logic        owner
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("dmi_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        req_valid_q, req_valid_d;
  logic        rsp_ready_q, rsp_ready_d;
  logic        m0_rsp_valid_q, m0_rsp_valid_d;
  logic        m1_rsp_valid_q, m1_rsp_valid_d;
  logic        busy_q, busy_d;

  logic grant;
  logic req_hs;
  logic owner_rsp_ready;

  // Favoured requester wins if it is asking; otherwise the other one.
  assign grant           = prio_q ? m1_req_valid : !m0_req_valid;
  assign req_hs          = m0_req_ready | m1_req_ready;
  assign owner_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            timeout;

  // Saturating; fires on the cycle whose increment reaches the limit.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign timeout = (cnt_inc == CntMax);
`endif

  // State and registered-output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= StIdle;
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      op_q           <= '0;
      rdata_q        <= '0;
      resp_q         <= '0;
      req_valid_q    <= 1'b0;
      rsp_ready_q    <= 1'b0;
      m0_rsp_valid_q <= 1'b0;
      m1_rsp_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      prio_q         <= prio_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      op_q           <= op_d;
      rdata_q        <= rdata_d;
      resp_q         <= resp_d;
      req_valid_q    <= req_valid_d;
      rsp_ready_q    <= rsp_ready_d;
      m0_rsp_valid_q <= m0_rsp_valid_d;
      m1_rsp_valid_q <= m1_rsp_valid_d;
      busy_q         <= busy_d;
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  // Next-state, datapath capture and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
`ifdef DMI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          state_d = StIssue;
          owner_d = grant;
          addr_d  = grant ? m1_req_addr : m0_req_addr;
          wdata_d = grant ? m1_req_data : m0_req_data;
          op_d    = grant ? m1_req_op : m0_req_op;
`ifdef DMI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StIssue: begin
        if (dmi_req_ready) state_d = StWait;
`ifdef DMI_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
        if (timeout) begin
          state_d = StDeliver;
          rdata_d = '0;
          resp_d  = 2'd2;
        end
`endif
      end
      StWait: begin
`ifdef DMI_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
        if (timeout) begin
          state_d = StDeliver;
          rdata_d = '0;
          resp_d  = 2'd2;
        end
`endif
        // A real response arriving on the timeout cycle still wins.
        if (dmi_rsp_valid) begin
          state_d = StDeliver;
          rdata_d = dmi_rsp_data;
          resp_d  = dmi_rsp_response;
        end
      end
      StDeliver: begin
        if (owner_rsp_ready) begin
          state_d = StIdle;
          prio_d  = !owner_q;
        end
      end
      default: state_d = StIdle;
    endcase

    req_valid_d    = (state_d == StIssue);
    rsp_ready_d    = (state_d == StWait);
    busy_d         = (state_d != StIdle);
    m0_rsp_valid_d = (state_d == StDeliver) && !owner_d;
    m1_rsp_valid_d = (state_d == StDeliver) && owner_d;
  end

  // Combinational request ready: only the granted, requesting master, only in IDLE.
  always_comb begin
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    if (state_q == StIdle && RST_N) begin
      m0_req_ready = m0_req_valid && !grant;
      m1_req_ready = m1_req_valid && grant;
    end
  end

  assign dmi_req_valid   = req_valid_q;
  assign dmi_req_addr    = addr_q;
  assign dmi_req_data    = wdata_q;
  assign dmi_req_op      = op_q;
  assign dmi_rsp_ready   = rsp_ready_q;
  assign m0_rsp_valid    = m0_rsp_valid_q;
  assign m1_rsp_valid    = m1_rsp_valid_q;
  assign m0_rsp_data     = rdata_q;
  assign m1_rsp_data     = rdata_q;
  assign m0_rsp_response = resp_q;
  assign m1_rsp_response = resp_q;
  assign busy            = busy_q;
  assign owner           = owner_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter with a response scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmi_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
  logic [6:0]  m0_req_addr;
  logic [31:0] m0_req_data, m0_rsp_data;
  logic [1:0]  m0_req_op, m0_rsp_response;
  logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
  logic [6:0]  m1_req_addr;
  logic [31:0] m1_req_data, m1_rsp_data;
  logic [1:0]  m1_req_op, m1_rsp_response;
  logic        dmi_req_valid, dmi_req_ready, dmi_rsp_ready, dmi_rsp_valid;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data, dmi_rsp_data;
  logic [1:0]  dmi_req_op, dmi_rsp_response;
  logic        busy, owner;

  always #5 CLK = ~CLK;

  dmi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_data(m0_req_data), .m0_req_op(m0_req_op), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_data(m0_rsp_data), .m0_rsp_response(m0_rsp_response),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_data(m1_req_data), .m1_req_op(m1_req_op), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_data(m1_rsp_data), .m1_rsp_response(m1_rsp_response),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr),
    .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data),
    .dmi_rsp_response(dmi_rsp_response), .busy(busy), .owner(owner)
  );

  typedef struct {
    bit          who;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rv(input bit who);
    return who ? m1_rsp_valid : m0_rsp_valid;
  endfunction

  function automatic logic rq(input bit who);
    return who ? m1_req_ready : m0_req_ready;
  endfunction

  function automatic logic [31:0] rdat(input bit who);
    return who ? m1_rsp_data : m0_rsp_data;
  endfunction

  function automatic logic [1:0] rrsp(input bit who);
    return who ? m1_rsp_response : m0_rsp_response;
  endfunction

  task automatic set_req(input bit who, input logic v, input logic [6:0] a, input logic [31:0] d,
                         input logic [1:0] op);
    if (who) begin
      m1_req_valid = v; m1_req_addr = a; m1_req_data = d; m1_req_op = op;
    end else begin
      m0_req_valid = v; m0_req_addr = a; m0_req_data = d; m0_req_op = op;
    end
  endtask

  task automatic set_rsp_ready(input bit who, input logic v);
    if (who) m1_rsp_ready = v;
    else     m0_rsp_ready = v;
  endtask

  task automatic push_exp(input bit who, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.who = who; e.data = d; e.resp = r;
    sb.push_back(e);
  endtask

  // Called on the first cycle a response should be visible to `who`.
  task automatic check_rsp(input bit who);
    exp_t e;
    chk("rsp_valid_owner", rv(who), 1'b1);
    chk("rsp_valid_other", rv(!who), 1'b0);
    n_vec++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL sb_pop: observed empty scoreboard expected a pending response");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_owner_idx", who, e.who);
      chk("rsp_data", rdat(who), e.data);
      chk("rsp_response", rrsp(who), e.resp);
      last_rd = e.data;
    end
  endtask

  task automatic wait_grant(input bit who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (rq(who) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_vec++;
    assert (ok) else begin
      n_err++;
      $error("FAIL grant_wait: requester %0d observed no ready expected ready within 50", who);
    end
  endtask

  // One complete transaction; entered and left on a falling edge.
  task automatic do_txn(input bit who, input logic [6:0] a, input logic [31:0] d,
                        input logic [1:0] op, input int req_dly, input int rsp_dly,
                        input int ack_dly, input logic [31:0] rd, input logic [1:0] rr);
    bit ok;
    set_req(who, 1'b1, a, d, op);
    wait_grant(who, ok);
    if (!ok) return;
    chk("ready_other", rq(!who), 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    set_req(who, 1'b0, '0, '0, '0);
    chk("issue_valid", dmi_req_valid, 1'b1);
    chk("issue_addr", dmi_req_addr, a);
    chk("issue_data", dmi_req_data, d);
    chk("issue_op", dmi_req_op, op);
    chk("issue_owner", owner, who);
    chk("issue_busy", busy, 1'b1);
    chk("issue_rsp_ready", dmi_rsp_ready, 1'b0);
    for (int i = 0; i < req_dly; i++) begin
      @(negedge CLK);
      chk("bp_req_valid", dmi_req_valid, 1'b1);
      chk("bp_req_addr", dmi_req_addr, a);
      chk("bp_req_data", dmi_req_data, d);
      chk("bp_req_op", dmi_req_op, op);
    end
    dmi_req_ready = 1'b1;
    @(negedge CLK);
    dmi_req_ready = 1'b0;
    chk("wait_req_valid", dmi_req_valid, 1'b0);
    chk("wait_rsp_ready", dmi_rsp_ready, 1'b1);
    chk("wait_no_rsp", rv(who), 1'b0);
    for (int i = 0; i < rsp_dly; i++) begin
      @(negedge CLK);
      chk("wait_rsp_ready_hold", dmi_rsp_ready, 1'b1);
      chk("wait_no_rsp_hold", rv(who), 1'b0);
    end
    push_exp(who, rd, rr);
    dmi_rsp_valid = 1'b1; dmi_rsp_data = rd; dmi_rsp_response = rr;
    @(negedge CLK);
    dmi_rsp_valid = 1'b0; dmi_rsp_data = ~rd; dmi_rsp_response = ~rr;
    check_rsp(who);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge CLK);
      chk("hold_rsp_valid", rv(who), 1'b1);
      chk("hold_rsp_data", rdat(who), rd);
      chk("hold_rsp_resp", rrsp(who), rr);
      chk("hold_no_grant", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
    end
    set_rsp_ready(who, 1'b1);
    @(negedge CLK);
    set_rsp_ready(who, 1'b0);
    chk("done_rsp_valid", rv(who), 1'b0);
    chk("done_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    logic seen;
    RST_N = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
    dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_data = '0; dmi_rsp_response = '0;
    repeat (3) @(negedge CLK);

    // Reset values
    chk("rst_dmi_req_valid", dmi_req_valid, 1'b0);
    chk("rst_dmi_rsp_ready", dmi_rsp_ready, 1'b0);
    chk("rst_dmi_req_addr", dmi_req_addr, 7'd0);
    chk("rst_rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
    chk("rst_rsp_data", m0_rsp_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Simultaneous pair after reset: m0 first, then m1
    set_req(1, 1'b1, 7'h11, 32'h0, 2'd1);
    do_txn(0, 7'h10, 32'h1, 2'd2, 0, 0, 0, 32'h0, 2'd0);
    do_txn(1, 7'h11, 32'h0, 2'd1, 0, 0, 0, 32'h0000_00A5, 2'd0);

    // Single read by m0, response two cycles into WAIT
    do_txn(0, 7'h11, 32'h0, 2'd1, 0, 2, 0, 32'h0040_0002, 2'd0);

    // Simultaneous pair after an m0 transaction: m1 first
    set_req(0, 1'b1, 7'h22, 32'hCAFE_0001, 2'd2);
    do_txn(1, 7'h23, 32'h0, 2'd1, 0, 1, 0, 32'h1234_5678, 2'd3);
    do_txn(0, 7'h22, 32'hCAFE_0001, 2'd2, 0, 0, 0, 32'h0, 2'd0);

    // Backpressure on m1 with m0 waiting: no grant to m0 until m1's handshake
    set_req(0, 1'b1, 7'h30, 32'h5555_AAAA, 2'd2);
    do_txn(1, 7'h31, 32'h0, 2'd1, 5, 0, 3, 32'h8765_4321, 2'd2);
    do_txn(0, 7'h30, 32'h5555_AAAA, 2'd2, 0, 0, 0, 32'h0000_0077, 2'd0);

    // Spurious downstream response while idle
    dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'hDEAD_BEEF; dmi_rsp_response = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("spur_rsp_ready", dmi_rsp_ready, 1'b0);
      chk("spur_rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
      chk("spur_busy", busy, 1'b0);
      chk("spur_rsp_data", m0_rsp_data, last_rd);
    end
    dmi_rsp_valid = 1'b0;
    do_txn(0, 7'h12, 32'h0, 2'd1, 0, 0, 0, 32'h0BAD_F00D, 2'd0);

    // Asynchronous reset in WAIT with m1 owning
    set_req(1, 1'b1, 7'h45, 32'h1111_2222, 2'd2);
    wait_grant(1, ok);
    @(posedge CLK);
    @(negedge CLK);
    set_req(1, 1'b0, '0, '0, '0);
    dmi_req_ready = 1'b1;
    @(negedge CLK);
    dmi_req_ready = 1'b0;
    chk("pre_rst_wait", dmi_rsp_ready, 1'b1);
    chk("pre_rst_owner", owner, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_rsp_ready", dmi_rsp_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_owner", owner, 1'b0);
    chk("arst_req_addr", dmi_req_addr, 7'd0);
    chk("arst_req_data", dmi_req_data, 32'd0);
    chk("arst_req_op", dmi_req_op, 2'd0);
    chk("arst_rsp_data", m1_rsp_data, 32'd0);
    chk("arst_rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    do_txn(1, 7'h46, 32'h0, 2'd1, 0, 0, 0, 32'h3C3C_3C3C, 2'd0);

`ifdef DMI_ARB_TIMEOUT_EN
    // Downstream never accepts: failed response 8 cycles after issue
    set_req(0, 1'b1, 7'h50, 32'h0, 2'd1);
    wait_grant(0, ok);
    @(posedge CLK);
    @(negedge CLK);
    set_req(0, 1'b0, '0, '0, '0);
    push_exp(0, 32'h0, 2'd2);
    chk("to_issue", dmi_req_valid, 1'b1);
    for (int i = 1; i < 8; i++) begin
      @(negedge CLK);
      chk("to_still_issue", dmi_req_valid, 1'b1);
      chk("to_no_rsp", m0_rsp_valid, 1'b0);
    end
    @(negedge CLK);
    chk("to_req_dropped", dmi_req_valid, 1'b0);
    check_rsp(0);
    // Late response to the abandoned request is not captured
    dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h1234_5678; dmi_rsp_response = 2'd0;
    @(negedge CLK);
    dmi_rsp_valid = 1'b0;
    chk("to_late_ignored", m0_rsp_data, 32'h0);
    chk("to_late_resp", m0_rsp_response, 2'd2);
    m0_rsp_ready = 1'b1;
    @(negedge CLK);
    m0_rsp_ready = 1'b0;
    chk("to_done_busy", busy, 1'b0);
`else
    // No timeout: still waiting after 1000 cycles
    set_req(0, 1'b1, 7'h50, 32'h0, 2'd1);
    wait_grant(0, ok);
    @(posedge CLK);
    @(negedge CLK);
    set_req(0, 1'b0, '0, '0, '0);
    dmi_req_ready = 1'b1;
    @(negedge CLK);
    dmi_req_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (m0_rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("nto_no_rsp", seen, 1'b0);
    chk("nto_busy", busy, 1'b1);
    chk("nto_rsp_ready", dmi_rsp_ready, 1'b1);
    push_exp(0, 32'h0F0F_0F0F, 2'd0);
    dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h0F0F_0F0F; dmi_rsp_response = 2'd0;
    @(negedge CLK);
    dmi_rsp_valid = 1'b0;
    check_rsp(0);
    m0_rsp_ready = 1'b1;
    @(negedge CLK);
    m0_rsp_ready = 1'b0;
    chk("nto_done_busy", busy, 1'b0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
